// File: rtl/mmp_modexp_ctrl.sv
// Left-to-right square-and-multiply sequencer for RSA modexp: walks the exponent MSB-first,
// launching one IDDMM Montgomery multiply per state and selecting its operands and destination.
module mmp_modexp_ctrl #(
  parameter int K       = 128,
  parameter int N       = 32,
  parameter int EXP_MAX = N * K,
  parameter int LEN_W   = $clog2(EXP_MAX) + 1,
  parameter int ADDR_W  = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  exp_len,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              exp_rd_en,
  output logic [ADDR_W-1:0] exp_rd_addr,
  input  logic [K-1:0]      exp_rd_data,
  output logic              mm_req,
  input  logic              mm_done,
  output logic [2:0]        mm_x_sel,
  output logic [2:0]        mm_y_sel,
  output logic              mm_dst_sel
);

  localparam int KB = $clog2(K);
  localparam logic [LEN_W-1:0] EXP_MAX_V = LEN_W'(EXP_MAX);

  typedef enum logic [3:0] {
    S_IDLE, S_TOM, S_INIT, S_FETCH, S_LOAD, S_SQR, S_MUL, S_NEXT, S_FROM, S_FIN
  } state_t;

  state_t           state, state_nxt;
  logic [LEN_W-1:0] b, b_nxt;
  logic             len_zero, len_zero_nxt;
  logic             err_nxt;
  logic [K-1:0]     word;
  logic             issued;
  logic             op_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      b        <= '0;
      len_zero <= 1'b0;
      err      <= 1'b0;
      word     <= '0;
      issued   <= 1'b0;
    end else begin
      state    <= state_nxt;
      b        <= b_nxt;
      len_zero <= len_zero_nxt;
      err      <= err_nxt;
      // issued marks that mm_req already fired for the op state we remain in
      issued   <= op_state && (state_nxt == state);
      if (state == S_LOAD) word <= exp_rd_data;
    end
  end

  always_comb begin
    state_nxt    = state;
    b_nxt        = b;
    len_zero_nxt = len_zero;
    err_nxt      = 1'b0;
    op_state     = 1'b0;
    mm_x_sel     = 3'd0;
    mm_y_sel     = 3'd0;
    mm_dst_sel   = 1'b0;
    busy         = (state != S_IDLE);
    done         = 1'b0;
    exp_rd_en    = 1'b0;
    exp_rd_addr  = '0;
    case (state)
      S_IDLE: begin
        if (start) begin
          b_nxt        = exp_len - LEN_W'(1);
          len_zero_nxt = (exp_len == '0);
          if (exp_len > EXP_MAX_V) err_nxt = 1'b1;
          else                     state_nxt = S_TOM;
        end
      end
      S_TOM: begin
        op_state = 1'b1;
        mm_y_sel = 3'd1;
        if (mm_done) state_nxt = S_INIT;
      end
      S_INIT: begin
        op_state   = 1'b1;
        mm_x_sel   = 3'd1;
        mm_y_sel   = 3'd3;
        mm_dst_sel = 1'b1;
        if (mm_done) state_nxt = len_zero ? S_FROM : S_FETCH;
      end
      S_FETCH: begin
        exp_rd_en   = 1'b1;
        exp_rd_addr = ADDR_W'(b >> KB);
        state_nxt   = S_LOAD;
      end
      S_LOAD: state_nxt = S_SQR;
      S_SQR: begin
        op_state   = 1'b1;
        mm_x_sel   = 3'd2;
        mm_y_sel   = 3'd2;
        mm_dst_sel = 1'b1;
        if (mm_done) state_nxt = word[b[KB-1:0]] ? S_MUL : S_NEXT;
      end
      S_MUL: begin
        op_state   = 1'b1;
        mm_x_sel   = 3'd2;
        mm_y_sel   = 3'd4;
        mm_dst_sel = 1'b1;
        if (mm_done) state_nxt = S_NEXT;
      end
      S_NEXT: begin
        if (b == '0) begin
          state_nxt = S_FROM;
        end else begin
          b_nxt = b - LEN_W'(1);
          // crossing into the next lower word when the current bit index is 0
          state_nxt = (b[KB-1:0] == '0) ? S_FETCH : S_SQR;
        end
      end
      S_FROM: begin
        op_state   = 1'b1;
        mm_x_sel   = 3'd2;
        mm_y_sel   = 3'd3;
        mm_dst_sel = 1'b1;
        if (mm_done) state_nxt = S_FIN;
      end
      S_FIN: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    mm_req = op_state && !issued;
  end

endmodule

// File: doc/mmp_modexp_ctrl.md
Name: mmp_modexp_ctrl

Overview:
- Left-to-right square-and-multiply sequencer for RSA modular exponentiation.
- Drives the IDDMM Montgomery multiplier through a request/done handshake and selects its operands and destination.
- Fetches exponent words from the exponent RAM, one word at a time.
- Sits between the RSA register interface (start/done) and the IDDMM multiplier plus its operand banks.

Parameters:
- K, 128, exponent RAM word width in bits; must be a power of 2.
- N, 32, number of exponent words.
- EXP_MAX, N*K, maximum exponent length in bits.
- LEN_W, $clog2(EXP_MAX)+1, width of exp_len.
- ADDR_W, $clog2(N), width of the exponent RAM address.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle start pulse; ignored while busy.
- exp_len  in  LEN_W  exponent bit length; sampled on start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at completion; result is in the ACC bank.
- err  out  1  one-cycle pulse when exp_len > EXP_MAX; no multiplier ops issued.
- exp_rd_en  out  1  exponent RAM read strobe.
- exp_rd_addr  out  ADDR_W  exponent word address.
- exp_rd_data  in  K  exponent word; valid exactly 1 cycle after exp_rd_en.
- mm_req  out  1  one-cycle pulse that launches one Montgomery multiply.
- mm_done  in  1  one-cycle completion pulse from the multiplier.
- mm_x_sel  out  3  X operand select: 0 BASE, 1 R2, 2 ACC, 3 ONE, 4 BASE_M.
- mm_y_sel  out  3  Y operand select, same encoding as mm_x_sel.
- mm_dst_sel  out  1  result destination: 0 BASE_M, 1 ACC.

Behaviour:
- Reset values: all outputs 0; state IDLE; internal counters 0.
- Reset mid-operation returns to IDLE next cycle with no done or err; any later mm_done is ignored.
- States and transitions:
  - IDLE: on start, latch exp_len and set b = exp_len-1.
    - exp_len > EXP_MAX: err pulses the next cycle, stay IDLE.
    - Otherwise go to TOM.
  - TOM: BASE_M = MM(BASE, R2); then INIT.
  - INIT: ACC = MM(R2, ONE); then FETCH if exp_len != 0, else FROM.
  - FETCH: exp_rd_en=1 for one cycle, exp_rd_addr = b / K; then LOAD.
  - LOAD: capture exp_rd_data into a K-bit shift register; then SQR.
  - SQR: ACC = MM(ACC, ACC).
    - Exponent bit (b % K) is 1: go to MUL.
    - Bit is 0: go to NEXT.
  - MUL: ACC = MM(ACC, BASE_M); then NEXT.
  - NEXT (1 cycle):
    - b == 0: go to FROM.
    - Otherwise decrement b; if the new b % K == K-1 go to FETCH, else SQR.
  - FROM: ACC = MM(ACC, ONE); then FIN.
  - FIN: done=1 for one cycle; go to IDLE.
- Multiply op states (TOM, INIT, SQR, MUL, FROM):
  - mm_req pulses exactly in the first cycle of the state.
  - mm_x_sel, mm_y_sel and mm_dst_sel are set in that same cycle and held stable until the cycle mm_done is seen.
  - The state advances the cycle after mm_done.
  - mm_done arriving in the same cycle as mm_req is legal and completes the op.
  - mm_done outside an op state is ignored.
- Selects return to 0 outside op states.
- Exponent bits are processed MSB-first starting at bit exp_len-1. Leading zero bits are legal and cost one SQR each.
- Total mm_req count = 3 + exp_len + popcount(exponent[exp_len-1:0]).
- exp_len == 0 gives result 1: 3 ops, no exponent reads.
- start while busy is ignored.
- busy stays low in the error case.
- done and err never assert together.

Test Plan:
- Reset with rst=1 held 3 cycles mid-SQR -> all outputs 0 the next cycle; later mm_done produces no activity.
- exp_len=3, word0=0x5, mm_done 4 cycles after each mm_req -> 8 mm_req with (x,y,dst) sequence (0,1,0) (1,3,1) (2,2,1) (2,4,1) (2,2,1) (2,2,1) (2,4,1) (2,3,1); one read at addr 0; one done.
- exp_len=130, word1 bit1=1, bit0=0, word0=0 -> reads at addr 1 then addr 0; the addr-0 read occurs after the 2nd SQR; mm_req count = 3+130+1 = 134.
- exp_len=0 -> 3 ops (TOM, INIT, FROM), exp_rd_en never asserts, then done.
- exp_len=EXP_MAX+1 -> err pulse one cycle after start, busy stays 0, no mm_req.
- start pulsed during busy, and mm_done returned in the same cycle as mm_req -> second start ignored; op accepted and advances next cycle; op count unchanged.
